bus_io: RTL

- Memory-bus splitter between the CPU's byte bus and RAM, with a small UART peripheral memory-mapped into a 16-byte I/O window.
- Outside the window, addresses, write strobes and read data pass straight through to/from RAM.
- Inside the window, it decodes the CPU's byte writes into a TX FIFO and control bits, and returns status/RX data combinationally.
- Instantiated once at top level, directly downstream of the CPU.

---
 rtl/bus_io.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/bus_io.sv
// CPU byte-bus splitter: RAM pass-through plus a 16-byte I/O window holding a UART
// with a TX FIFO, an 8N1 transmitter and an oversampling-free mid-bit receiver.
module bus_io #(
  parameter int unsigned CLK_HZ     = 25000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [15:0] IO_BASE    = 16'hFF00
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic [15:0] I_ADDR,
  input  logic [7:0]  I_DATA,
  input  logic        I_WREN,
  output logic [7:0]  O_DATA,
  output logic        O_RAM_WREN,
  input  logic [7:0]  I_RAM_DATA,
  output logic        O_TX,
  input  logic        I_RX
);

  localparam int unsigned DIV_RAW = CLK_HZ / BAUD;
  localparam int unsigned DIV     = (DIV_RAW < 4) ? 4 : DIV_RAW;
  localparam int unsigned BCW     = $clog2(DIV);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = AW + 1;
  localparam logic [BCW-1:0] BAUD_LAST  = BCW'(DIV - 1);
  localparam logic [BCW-1:0] HALF_LAST  = BCW'(DIV / 2 - 1);
  localparam logic [CW-1:0]  FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Address decode and register write strobes
  logic       io_sel;
  logic [3:0] offset;
  logic       wr_data, wr_status;
  logic       clr_rdy, clr_ovf, clr_ovr;

  assign io_sel     = (I_ADDR[15:4] == IO_BASE[15:4]);
  assign offset     = I_ADDR[3:0];
  assign wr_data    = io_sel & I_WREN & (offset == 4'd0);
  assign wr_status  = io_sel & I_WREN & (offset == 4'd1);
  assign clr_rdy    = wr_status & I_DATA[2];
  assign clr_ovf    = wr_status & I_DATA[3];
  assign clr_ovr    = wr_status & I_DATA[4];
  assign O_RAM_WREN = I_WREN & ~io_sel;

  // TX FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] tx_count;
  logic          fifo_empty, fifo_full, push, tx_pop, tx_ovf;

  assign fifo_empty = (tx_count == '0);
  assign fifo_full  = (tx_count == FULL_COUNT);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push       = wr_data & (~fifo_full | tx_pop);

  always_ff @(posedge CLOCK) begin
    if (push) fifo_mem[wr_ptr] <= I_DATA;
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_count <= '0;
      tx_ovf   <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (tx_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, tx_pop})
        2'b10:   tx_count <= tx_count + CW'(1);
        2'b01:   tx_count <= tx_count - CW'(1);
        default: tx_count <= tx_count;
      endcase
      if (wr_data & ~push) tx_ovf <= 1'b1;
      else if (clr_ovf)    tx_ovf <= 1'b0;
    end
  end

  // TX shifter
  tx_state_t      tx_state, tx_state_n;
  logic [BCW-1:0] tx_baud;
  logic [2:0]     tx_bit;
  logic [7:0]     tx_sh;
  logic           tx_q, tx_tick, tx_idle;

  assign tx_tick = (tx_baud == BAUD_LAST);
  assign tx_idle = fifo_empty & (tx_state == TX_IDLE);
  assign O_TX    = tx_q;

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) tx_state <= TX_IDLE;
    else          tx_state <= tx_state_n;
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE:  if (!fifo_empty) begin tx_pop = 1'b1; tx_state_n = TX_START; end
      TX_START: if (tx_tick) tx_state_n = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_state_n = TX_STOP;
      TX_STOP:  if (tx_tick) begin
                  if (!fifo_empty) begin tx_pop = 1'b1; tx_state_n = TX_START; end
                  else tx_state_n = TX_IDLE;
                end
      default:  tx_state_n = TX_IDLE;
    endcase
  end

  // Line is registered one step ahead: each tick loads the level of the next bit.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      tx_baud <= '0;
      tx_bit  <= '0;
      tx_sh   <= '0;
      tx_q    <= 1'b1;
    end else if (tx_pop) begin
      tx_sh   <= fifo_mem[rd_ptr];
      tx_baud <= '0;
      tx_bit  <= '0;
      tx_q    <= 1'b0;
    end else if (tx_state != TX_IDLE) begin
      if (tx_tick) begin
        tx_baud <= '0;
        case (tx_state)
          TX_START: tx_q <= tx_sh[0];
          TX_DATA: begin
            tx_bit <= tx_bit + 3'd1;
            tx_sh  <= {1'b0, tx_sh[7:1]};
            tx_q   <= (tx_bit == 3'd7) ? 1'b1 : tx_sh[1];
          end
          default: tx_q <= 1'b1;
        endcase
      end else begin
        tx_baud <= tx_baud + BCW'(1);
      end
    end
  end

  // RX path
  rx_state_t      rx_state, rx_state_n;
  logic           rx_s1, rx_s2, rx_prev;
  logic [BCW-1:0] rx_baud;
  logic [2:0]     rx_bit;
  logic [7:0]     rx_sh, rx_hold;
  logic           rx_ready, rx_ovr, rx_half, rx_full, rx_done;

  assign rx_half = (rx_baud == HALF_LAST);
  assign rx_full = (rx_baud == BAUD_LAST);
  assign rx_done = (rx_state == RX_STOP) & rx_full;

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) rx_state <= RX_IDLE;
    else          rx_state <= rx_state_n;
  end

  always_comb begin
    rx_state_n = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev & ~rx_s2) rx_state_n = RX_START;
      RX_START: if (rx_half) rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_full && rx_bit == 3'd7) rx_state_n = RX_STOP;
      RX_STOP:  if (rx_full) rx_state_n = RX_IDLE;
      default:  rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_hold  <= '0;
      rx_ready <= 1'b0;
      rx_ovr   <= 1'b0;
    end else begin
      rx_s1   <= I_RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (rx_state == RX_IDLE || rx_state_n != rx_state || rx_full) rx_baud <= '0;
      else rx_baud <= rx_baud + BCW'(1);
      if (rx_state != RX_DATA) rx_bit <= '0;
      else if (rx_full) begin
        rx_bit <= rx_bit + 3'd1;
        rx_sh  <= {rx_s2, rx_sh[7:1]};
      end
      if (rx_done) rx_hold <= rx_sh;
      // A clear landing with completion is consumed by the new byte, not an overrun.
      if (rx_done & rx_ready & ~clr_rdy) rx_ovr <= 1'b1;
      else if (clr_ovr)                  rx_ovr <= 1'b0;
      if (rx_done)      rx_ready <= 1'b1;
      else if (clr_rdy) rx_ready <= 1'b0;
    end
  end

  // Register read mux
  logic [8:0] count9;
  logic [7:0] count_disp, rd_reg;

  assign count9     = 9'(tx_count);
  assign count_disp = count9[8] ? 8'hFF : count9[7:0];

  always_comb begin
    rd_reg = '0;
    case (offset)
      4'd0:    rd_reg = rx_hold;
      4'd1:    rd_reg = {3'b000, rx_ovr, tx_ovf, rx_ready, tx_idle, fifo_full};
      4'd2:    rd_reg = count_disp;
      default: rd_reg = '0;
    endcase
  end

  assign O_DATA = io_sel ? rd_reg : I_RAM_DATA;

endmodule
